dadda_24_multiplier: RTL and testbench

Unsigned 24×24-bit multiplier built from an AND partial-product array, a Dadda reduction tree and a final carry-propagate adder. The output is registered. It serves as the mantissa multiplier in the datapath: 24-bit significands with the hidden bit included. It returns the low 47 bits of the product.

---
 rtl/dadda_24_multiplier_if.sv | 8 +
 rtl/dadda_24_multiplier.sv | 85 ++++++++
 tb/tb_dadda_24_multiplier.sv | 117 +++++++++++
 3 files changed

// File: rtl/dadda_24_multiplier_if.sv
// dadda_24_multiplier_if: operand and product bundle for the 24x24 mantissa multiplier
interface dadda_24_multiplier_if;
  logic [23:0] A;
  logic [23:0] B;
  logic [46:0] mul_result;
  modport master (output A, output B, input mul_result);
  modport slave (input A, input B, output mul_result);
endinterface

// File: rtl/dadda_24_multiplier.sv
// dadda_24_multiplier: registered 24x24 unsigned Dadda-tree multiplier returning the low 47 product bits
module dadda_24_multiplier (
  input logic clk,
  input logic rst,
  dadda_24_multiplier_if.slave bus
);
  logic [93:0] rows;
  function automatic logic [93:0] reduce(input logic [23:0] a, input logic [23:0] b);
    logic [23:0] cur [48];
    logic [23:0] nxt [48];
    int h [48];
    int nh [48];
    int tgt [7];
    int cin, e, f, ha, p;
    logic x, y, z;
    logic [46:0] r0, r1;
    tgt = '{19, 13, 9, 6, 4, 3, 2};
    for (int c = 0; c < 48; c++) begin
      cur[c] = '0;
      nxt[c] = '0;
      h[c] = 0;
      nh[c] = 0;
    end
    for (int i = 0; i < 24; i++)
      for (int j = 0; j < 24; j++) begin
        cur[i + j][h[i + j]] = a[j] & b[i];
        h[i + j]++;
      end
    for (int s = 0; s < 7; s++) begin
      for (int c = 0; c < 48; c++) begin
        nxt[c] = '0;
        nh[c] = 0;
      end
      cin = 0;
      for (int c = 0; c < 48; c++) begin
        e = h[c] + cin - tgt[s];
        f = e > 0 ? e / 2 : 0;
        ha = e > 0 ? e % 2 : 0;
        p = 0;
        for (int k = 0; k < f; k++) begin
          x = cur[c][p];
          y = cur[c][p + 1];
          z = cur[c][p + 2];
          nxt[c][nh[c]] = x ^ y ^ z;
          nh[c]++;
          if (c < 47) begin
            nxt[c + 1][nh[c + 1]] = (x & y) | (z & (x ^ y));
            nh[c + 1]++;
          end
          p += 3;
        end
        if (ha > 0) begin
          x = cur[c][p];
          y = cur[c][p + 1];
          nxt[c][nh[c]] = x ^ y;
          nh[c]++;
          if (c < 47) begin
            nxt[c + 1][nh[c + 1]] = x & y;
            nh[c + 1]++;
          end
          p += 2;
        end
        while (p < h[c]) begin
          nxt[c][nh[c]] = cur[c][p];
          nh[c]++;
          p++;
        end
        cin = f + ha;
      end
      for (int c = 0; c < 48; c++) begin
        cur[c] = nxt[c];
        h[c] = nh[c];
      end
    end
    r0 = '0;
    r1 = '0;
    for (int c = 0; c < 47; c++) begin
      r0[c] = cur[c][0];
      r1[c] = cur[c][1];
    end
    return {r1, r0};
  endfunction
  always_comb rows = reduce(bus.A, bus.B);
  always_ff @(posedge clk) bus.mul_result <= rst ? '0 : rows[46:0] + rows[93:47];
endmodule

// File: tb/tb_dadda_24_multiplier.sv
// tb_dadda_24_multiplier: directed and random checks of the registered 24x24 multiplier
module tb_dadda_24_multiplier;
  logic clk = 0;
  logic rst = 1;
  int vectors = 0;
  int miscompares = 0;
  dadda_24_multiplier_if bus ();
  dadda_24_multiplier dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic drive(input logic [23:0] a, input logic [23:0] b);
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      drive(24'hFFFFFF, 24'hFFFFFF);
      vectors++;
      if (bus.mul_result !== 47'h0) begin
        miscompares++;
        $display("FAIL reset_hold[%0d]: got %h expected %h", i, bus.mul_result, 47'h0);
      end
    end
    rst = 0;
    drive(24'hFFFFFF, 24'hFFFFFF);
    vectors++;
    if (bus.mul_result !== 47'h7FFFFE000001) begin
      miscompares++;
      $display("FAIL reset_release: got %h expected %h", bus.mul_result, 47'h7FFFFE000001);
    end
  endtask
  task automatic test_directed();
    logic [23:0] av [4] = '{24'h0E9500, 24'h03E800, 24'h07D000, 24'h0BB800};
    logic [23:0] bv [4] = '{24'h04D200, 24'h03E900, 24'h07D100, 24'h0BB900};
    logic [46:0] ev [4] = '{47'h464A3A0000, 47'hF46280000, 47'h3D10D00000, 47'h895FF80000};
    for (int i = 0; i < 4; i++) begin
      drive(av[i], bv[i]);
      vectors++;
      if (bus.mul_result !== ev[i]) begin
        miscompares++;
        $display("FAIL directed[%0d]: got %h expected %h", i, bus.mul_result, ev[i]);
      end
    end
  endtask
  task automatic test_zero_identity();
    logic [23:0] av [3] = '{24'h000000, 24'h000001, 24'h800000};
    logic [23:0] bv [3] = '{24'hABCDEF, 24'hABCDEF, 24'h000001};
    logic [46:0] ev [3] = '{47'h0, 47'hABCDEF, 47'h800000};
    for (int i = 0; i < 3; i++) begin
      drive(av[i], bv[i]);
      vectors++;
      if (bus.mul_result !== ev[i]) begin
        miscompares++;
        $display("FAIL zero_identity[%0d]: got %h expected %h", i, bus.mul_result, ev[i]);
      end
    end
  endtask
  task automatic test_truncation();
    drive(24'h800000, 24'h800000);
    vectors++;
    if (bus.mul_result !== 47'h400000000000) begin
      miscompares++;
      $display("FAIL trunc_2e46: got %h expected %h", bus.mul_result, 47'h400000000000);
    end
    drive(24'hC00000, 24'hC00000);
    vectors++;
    if (bus.mul_result !== 47'h100000000000) begin
      miscompares++;
      $display("FAIL trunc_bit47: got %h expected %h", bus.mul_result, 47'h100000000000);
    end
  endtask
  task automatic test_walking_one();
    logic [46:0] exp;
    for (int k = 0; k < 24; k++) begin
      exp = 47'hFFFFFF << k;
      drive(24'h1 << k, 24'hFFFFFF);
      vectors++;
      if (bus.mul_result !== exp) begin
        miscompares++;
        $display("FAIL walking_one[%0d]: got %h expected %h", k, bus.mul_result, exp);
      end
    end
  endtask
  task automatic test_back_to_back_random();
    logic [23:0] a, b;
    logic [47:0] full;
    logic [46:0] exp;
    for (int i = 0; i < 10000; i++) begin
      a = 24'($urandom);
      b = 24'($urandom);
      rst = (i >= 5000 && i < 5003);
      full = {24'h0, a} * {24'h0, b};
      exp = rst ? 47'h0 : full[46:0];
      drive(a, b);
      vectors++;
      if (bus.mul_result !== exp) begin
        miscompares++;
        $display("FAIL random[%0d] a=%h b=%h rst=%0b: got %h expected %h", i, a, b, rst, bus.mul_result, exp);
      end
    end
    rst = 0;
  endtask
  initial begin
    bus.A = '0;
    bus.B = '0;
    test_reset();
    test_directed();
    test_zero_identity();
    test_truncation();
    test_walking_one();
    test_back_to_back_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
